lzd_share_arbiter: RTL

Round-robin controller that shares a single 8-bit leading-zero detector (LZD) among N_REQ requesters. It grants one request at a time and latches that requester's operand. It drives the LZD's `en`/`in` pins, waits for `done` (with a timeout), and returns the zero count tagged with the requester index over a valid/ready response port. It sits between the normalization clients of the datapath and the one LZD instance.

---
 rtl/lzd_share_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/lzd_share_arbiter.sv
// Round-robin sharing of one leading-zero detector among N_REQ clients.
// Grants one request, runs the LZD with a timeout, returns a tagged count.
module lzd_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic               lzd_en,
    output logic [7:0]         lzd_in,
    input  logic [3:0]         lzd_out,
    input  logic               lzd_done,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [3:0]         rsp_count,
    output logic               rsp_err,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    logic            found;
    logic [3:0]      wait_cnt;
    logic            first;
    logic            hit;
    logic            tmo;

    // done is not trusted in the first RUN cycle; wait_cnt never returns to 0
    assign first = (wait_cnt == 4'd0);
    assign hit   = lzd_done && !first;
    assign tmo   = (wait_cnt == 4'(TIMEOUT));

    assign lzd_en    = (state == RUN);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // first set request at or after ptr, wrapping upward
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr + i[ID_W-1:0];
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic; done beats a simultaneous timeout
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (found) state_nx = RUN;
            RUN:  if (hit || tmo) state_nx = RESP;
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // grant, operand latch, wait counter and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            gnt       <= '0;
            lzd_in    <= '0;
            rsp_id    <= '0;
            rsp_count <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            gnt <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        lzd_in   <= req_data[8*win +: 8];
                        rsp_id   <= win;
                        gnt      <= N_REQ'(1) << win;
                        wait_cnt <= '0;
                        ptr      <= win + 1'b1;
                    end
                end
                RUN: begin
                    if (wait_cnt != 4'd15) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                    if (hit) begin
                        rsp_count <= lzd_out;
                        rsp_err   <= 1'b0;
                    end else if (tmo) begin
                        rsp_count <= 4'd8;
                        rsp_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
